// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and the
// legal WIDTH range.
package serial_add_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder1.sv
// Single-bit combinational full adder cell: the one bit-slice reused by the
// serial adder datapath.
module full_adder1 (
   input  logic Ai,
   input  logic Bi,
   input  logic Ci,
   output logic So,
   output logic Co
);

   assign So = Ai ^ Bi ^ Ci;
   assign Co = (Ai & Bi) | (Ci & (Ai ^ Bi));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands and a carry-in, adds them
// LSB-first through one full_adder1 slice (one bit per clock), and returns the
// registered sum and carry-out over a valid/ready handshake.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN, which adds
// the sub port (a - b via a + ~b + 1; cout=1 means no borrow).
module bit_serial_adder
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_SUB_EN
   ,
   input  logic             sub
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("bit_serial_adder: WIDTH out of legal range");
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] b_load;
   logic             carry_load;
   logic             fa_so;
   logic             fa_co;

   // Operand B and initial carry as loaded at accept (inverted B + 1 for subtract)
   always_comb begin
      b_load     = b;
      carry_load = cin;
`ifdef SERIAL_ADD_SUB_EN
      if (sub) begin
         b_load     = ~b;
         carry_load = 1'b1;
      end
`endif
   end

   full_adder1 u_fa (
      .Ai (a_sh[0]),
      .Bi (b_sh[0]),
      .Ci (carry),
      .So (fa_so),
      .Co (fa_co)
   );

   // Handshake FSM and serial datapath: load at accept, shift one bit per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_sh   <= a;
                  b_sh   <= b_load;
                  carry  <= carry_load;
                  sum_sh <= '0;
                  cnt    <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               sum_sh <= {fa_so, sum_sh[WIDTH-1:1]};
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               carry  <= fa_co;
               // Counter parks at the last index instead of wrapping
               if (cnt == CNT_LAST) begin
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs come straight from state and datapath registers
   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
      sum       = sum_sh;
      cout      = carry;
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed cases with
// literal expectations plus randomized operations checked every cycle against
// an arithmetic reference model. Define SERIAL_ADD_SUB_EN to cover subtract.
module tb_bit_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         m_sub;

   int checks = 0;
   int errors = 0;

`ifdef SERIAL_ADD_SUB_EN
   logic sub = 1'b0;
   assign m_sub = sub;
`else
   assign m_sub = 1'b0;
`endif

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef SERIAL_ADD_SUB_EN
      ,
      .sub       (sub)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result from plain arithmetic: {cout, sum}
   function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rc, input logic rs);
      logic [W-1:0]    nb;
      longint unsigned t;
      nb = ~rb;
      if (rs) t = longint'(ra) + longint'(nb) + 1;
      else    t = longint'(ra) + longint'(rb) + longint'(rc);
      return t[W:0];
   endfunction

   // Behavioural model: phase 0 idle, 1 computing (W cycles), 2 result held
   int           m_phase = 0;
   int           m_left = 0;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;
   logic [W-1:0] p_sum = '0;
   logic         p_cout = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_left  = 0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               {p_cout, p_sum} = ref_result(a, b, cin, m_sub);
               m_left  = W;
               m_phase = 1;
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = 2;
                  m_sum   = p_sum;
                  m_cout  = p_cout;
               end
            end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready, m_phase == 0);
         chk("out_valid", out_valid, m_phase == 2);
         if (m_phase == 2) begin
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
         end
      end
   end

   // Called at the negedge right after the accepting edge; returns edges counted
   task automatic wait_done(output int edges);
      int n;
      n = 1;
      while (!out_valid && n < 100) begin
         in_valid  = 1'($urandom_range(0, 1));
         a         = W'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      edges = n - 1;
   endtask

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input int hold, input bit lit,
                        input logic [W-1:0] es, input logic ec);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", n < 50, 1);
      in_valid = 1'b1;
      a = ta;
      b = tb;
      cin = tc;
`ifdef SERIAL_ADD_SUB_EN
      sub = ts;
`endif
      @(negedge clk);
      in_valid = 1'b0;
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      wait_done(n);
      chk("latency", n, W);
      if (lit) begin
         chk("lit_sum", sum, es);
         chk("lit_cout", cout, ec);
      end
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 8'h00);
      chk("rst_cout", cout, 0);
      @(negedge clk);

      do_op(8'h3C, 8'h05, 1'b0, 1'b0, 0, 1, 8'h41, 1'b0);
      do_op(8'hFF, 8'h01, 1'b1, 1'b0, 2, 1, 8'h01, 1'b1);
      do_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1, 8'h00, 1'b1);

      // Backpressure: result held while out_ready low; pending in_valid not taken
      in_valid = 1'b1;
      a = 8'h22;
      b = 8'h33;
      cin = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      wait_done(n);
      chk("bp_latency", n, W);
      in_valid = 1'b1;
      a = 8'h11;
      b = 8'h00;
      cin = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_sum", sum, 8'h55);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      wait_done(n);
      chk("bp2_latency", n, W);
      chk("bp2_sum", sum, 8'h11);
      chk("bp2_cout", cout, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset mid-run discards the operation
      in_valid = 1'b1;
      a = 8'hAA;
      b = 8'h55;
      cin = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 8'h00);
      chk("mid_rst_cout", cout, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_op(8'h01, 8'h02, 1'b0, 1'b0, 1, 1, 8'h03, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      do_op(8'h10, 8'h20, 1'b1, 1'b1, 0, 1, 8'hF0, 1'b0);
      do_op(8'h20, 8'h10, 1'b0, 1'b1, 0, 1, 8'h10, 1'b1);
`endif

      // Randomized operations checked by the model every cycle
      for (int i = 0; i < 40; i++) begin
         logic rs;
         rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         rs = 1'($urandom_range(0, 1));
`endif
         do_op(W'($urandom), W'($urandom), 1'($urandom), rs, $urandom_range(0, 3), 0,
               '0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential adder: accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, through a single instance of the existing combinational full_adder1 cell, with a registered carry.
- Returns sum and carry-out over a second valid/ready handshake.
- Sits directly upstream of full_adder1, sequencing its Ai/Bi/Ci inputs and consuming its So/Co outputs; serves as the area-minimal adder datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A, sampled only at accept
- b  input  WIDTH  operand B, sampled only at accept
- cin  input  1  carry-in, sampled only at accept
- out_valid  output  1  result available (high only in DONE)
- out_ready  input  1  downstream takes result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out
- sub  input  1  subtract request, present only with SERIAL_ADD_SUB_EN

Behaviour:
- Reset (async assert, any state): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; shift registers, carry and counter=0. Any in-flight operation is discarded, with no partial result.
- States:
  - IDLE: accept when in_valid & in_ready. Load a_sh<=a, b_sh<=b, carry<=cin, sum_sh<=0, cnt<=0, then go to RUN.
  - RUN: each cycle, full_adder1 takes (a_sh[0], b_sh[0], carry). Update sum_sh<={So, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1 with zero fill; carry<=Co; cnt<=cnt+1. When cnt==WIDTH-1, go to DONE.
  - DONE: out_valid=1; sum=sum_sh; cout=carry. Values hold stable until out_ready=1, then go to IDLE.
- Latency: out_valid rises exactly WIDTH rising edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum. No back-to-back accept in DONE; the next accept occurs in IDLE.
- in_valid during RUN or DONE is ignored, with no queuing. Changes to a, b, cin after accept have no effect.
- out_ready outside DONE is ignored.
- Arithmetic: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of a+b+cin.
- cnt width: $clog2(WIDTH), no wrap beyond WIDTH-1.
- sum and cout are driven from registers only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - The sub port exists and is sampled at accept.
  - With sub=1, b_sh loads ~b and carry loads 1 (cin ignored), giving sum = a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned).
  - With sub=0, the block behaves exactly as the add-only build.
- When undefined: no sub port, add-only, logic identical to the base description.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - WIDTH_MIN=2, WIDTH_MAX=32 for the parameter range check
- Sub-module: reuse full_adder1 as the single bit-slice (instance u_fa). No new sub-module.

Test Plan (WIDTH=8):
- Reset: hold rst=1 three cycles, then release -> in_ready=1, out_valid=0, sum=8'h00, cout=0.
- Add: a=8'h3C, b=8'h05, cin=0, accepted -> out_valid high exactly 8 edges later, sum=8'h41, cout=0.
- Carry chain: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1. Also a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE, in_valid=1 with a=8'h11 -> sum and out_valid held stable, in_ready=0, no new accept. Releasing out_ready gives IDLE, then 8'h11 is accepted.
- Reset mid-run: assert rst at RUN cycle 4 of a=8'hAA, b=8'h55 -> out_valid=0, sum=0 immediately. After release, a=8'h01, b=8'h02, cin=0 -> sum=8'h03.
- SERIAL_ADD_SUB_EN: a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0. a=8'h20, b=8'h10, sub=1 -> sum=8'h10, cout=1.
